// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared encodings for the memory port arbiter
package core_pkg;

  localparam int XLEN  = 32;
  // Wide enough to count a read latency of up to 4 cycles
  localparam int LAT_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/arb_starve_prio.sv
// rtl/arb_starve_prio.sv - data-first two-way arbiter with fetch starvation guard
module arb_starve_prio #(
  parameter int  STARVE_MAX = 4,
  localparam int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       if_valid,
  input  logic       d_valid,
  input  logic       accept,
  output logic [1:0] grant
);

  // Consecutive data grants handed out while fetch was left waiting
  logic [CNT_W-1:0] starve_cnt;

  // One-hot grant: bit 0 = fetch, bit 1 = data; data wins until fetch has waited too long
  always_comb begin
    grant = 2'b00;
    if (d_valid && (!if_valid || (starve_cnt < CNT_W'(STARVE_MAX)))) begin
      grant = 2'b10;
    end else if (if_valid) begin
      grant = 2'b01;
    end
  end

  // Starvation counter: cleared by a fetch grant, saturating bump when data jumps a waiting fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (accept) begin
      if (grant[0]) begin
        starve_cnt <= '0;
      end else if (grant[1] && if_valid && (starve_cnt != CNT_W'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch and load/store
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = XLEN,
  parameter int MEM_LATENCY = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_data,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic                d_req_we,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_wstrb,
  output logic                d_resp_valid,
  output logic [DATA_W-1:0]   d_resp_data,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);

  state_t           state_q, state_d;
  owner_t           owner_q;
  logic             we_q;
  logic [LAT_W-1:0] lat_cnt_q;
  logic [1:0]       grant;
  logic             accept;

  arb_starve_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_req_valid),
    .d_valid  (d_req_valid),
    .accept   (accept),
    .grant    (grant)
  );

  // Request steering in IDLE, response routing in BUSY; everything forced low while in reset
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    if_req_ready  = 1'b0;
    d_req_ready   = 1'b0;
    if_resp_valid = 1'b0;
    if_resp_data  = '0;
    d_resp_valid  = 1'b0;
    d_resp_data   = '0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wstrb     = '0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if_req_ready = grant[0];
          d_req_ready  = grant[1];
          accept       = |grant;
          mem_en       = accept;
          if (grant[1]) begin
            mem_we    = d_req_we;
            mem_addr  = d_req_addr;
            mem_wdata = d_req_wdata;
            mem_wstrb = d_req_wstrb;
          end else if (grant[0]) begin
            mem_addr = if_req_addr;
          end
          if (accept) begin
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (lat_cnt_q == LAT_W'(MEM_LATENCY)) begin
            if (owner_q == OWN_D) begin
              d_resp_valid = 1'b1;
              d_resp_data  = we_q ? '0 : mem_rdata;
            end else begin
              if_resp_valid = 1'b1;
              if_resp_data  = mem_rdata;
            end
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Transaction bookkeeping: who owns the in-flight access and how long it has been out
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_IF;
      we_q      <= 1'b0;
      lat_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q   <= grant[1] ? OWN_D : OWN_IF;
        we_q      <= grant[1] & d_req_we;
        lat_cnt_q <= LAT_W'(1);
      end else if (state_q == ST_BUSY) begin
        lat_cnt_q <= lat_cnt_q + LAT_W'(1);
      end
    end
  end

endmodule
